// File: rtl/psram_model_pkg.sv
// Shared types and helpers for the PSRAM burst model: FSM state encoding,
// counter-width helpers and the address-derived read pattern.
package psram_model_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMD  = 1'b1
    } state_e;

    // Widest beat the pattern helper can build; callers slice to DATA_WIDTH.
    localparam int PAT_MAX_W = 1024;

    // Timer counts 0..TCMD.
    function automatic int timer_width(input int tcmd);
        return $clog2(tcmd + 1);
    endfunction

    // Beat index counts 0..BURST_LEN-1; keep at least one bit for single-beat bursts.
    function automatic int beat_width(input int blen);
        return (blen > 1) ? $clog2(blen) : 1;
    endfunction

    // Replicated (seed ^ addr) words; the low DATA_WIDTH bits form one beat.
    function automatic logic [PAT_MAX_W-1:0] pattern_word(input logic [31:0] seed,
                                                          input logic [31:0] addr);
        logic [PAT_MAX_W-1:0] w;
        for (int i = 0; i < PAT_MAX_W / 32; i++) begin
            w[i*32 +: 32] = seed ^ addr;
        end
        return w;
    endfunction

endpackage

// File: rtl/psram_burst_model_if.sv
// User-side command bus of the PSRAM burst model. The master drives commands
// and write data; the slave (the model) returns read beats and status.
interface psram_burst_model_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 21
);
    logic                  i_cmd_en;
    logic                  i_cmd_wr;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_data_valid;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_cmd_err;
    logic                  o_cmd_err_sticky;

    modport master (
        output i_cmd_en, i_cmd_wr, i_addr, i_wr_data,
        input  o_rd_data, o_rd_data_valid, o_busy, o_done, o_cmd_err, o_cmd_err_sticky
    );

    modport slave (
        input  i_cmd_en, i_cmd_wr, i_addr, i_wr_data,
        output o_rd_data, o_rd_data_valid, o_busy, o_done, o_cmd_err, o_cmd_err_sticky
    );
endinterface

// File: rtl/psram_model_mem.sv
// Single-port synchronous RAM used as optional backing store. Read data is
// registered; contents are never cleared.
module psram_model_mem #(
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_q;

    // Write when enabled; always register the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_addr] <= i_wdata;
        rd_q <= mem_q[i_addr];
    end

    assign o_rdata = rd_q;
endmodule

// File: rtl/psram_burst_model.sv
// PSRAM controller user-side model: accepts read/write bursts, enforces
// command spacing, returns address-derived pattern data and flags commands
// issued while busy. Optional backing store under PSRAM_MODEL_MEM_EN.
module psram_burst_model
    import psram_model_pkg::*;
#(
    parameter int          DATA_WIDTH   = 64,
    parameter int          ADDR_WIDTH   = 21,
    parameter int          TCMD         = 19,
    parameter int          READ_LATENCY = 11,
    parameter int          BURST_LEN    = 8,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
    parameter int          MEM_AW       = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    psram_burst_model_if.slave  bus
);
    localparam int TW = timer_width(TCMD);
    localparam int BW = beat_width(BURST_LEN);
    localparam logic [TW-1:0] T_END  = TW'(TCMD);
    localparam logic [TW-1:0] WIN_LO = TW'(READ_LATENCY);
    localparam logic [TW-1:0] WIN_HI = TW'(READ_LATENCY + BURST_LEN - 1);

    if (READ_LATENCY < 2) begin : g_chk_rl
        $error("READ_LATENCY must be at least 2");
    end
    if (READ_LATENCY + BURST_LEN - 1 >= TCMD) begin : g_chk_win
        $error("beat window must end before TCMD");
    end
    if (DATA_WIDTH % 32 != 0) begin : g_chk_dw
        $error("DATA_WIDTH must be a multiple of 32");
    end

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;

    // Beat that will be presented next cycle (timer_d). The window never opens
    // on the accept cycle, so addr_q/wr_q are already the latched command.
    logic                  win_nxt;
    logic [BW-1:0]         beat_nxt;
    logic [ADDR_WIDTH-1:0] a_nxt;

    // Command FSM: idle until a strobe, then count to TCMD and return to idle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (bus.i_cmd_en) begin
                state_d = CMD;
                timer_d = TW'(1);
                addr_d  = bus.i_addr;
                wr_d    = bus.i_cmd_wr;
            end
            CMD: if (timer_q == T_END) begin
                state_d = IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
        err_d    = bus.i_cmd_en && (timer_q != '0);
        sticky_d = sticky_q | err_d;
        win_nxt  = (timer_d >= WIN_LO) && (timer_d <= WIN_HI);
        beat_nxt = BW'(timer_d - WIN_LO);
        a_nxt    = addr_q + ADDR_WIDTH'(beat_nxt);
        valid_d  = win_nxt && !wr_q;
    end

    // Control and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef PSRAM_MODEL_MEM_EN
    // Write beats use the current beat address; reads prefetch the next beat
    // so the registered RAM output lines up with valid_q.
    logic                  win_cur;
    logic [BW-1:0]         beat_cur;
    logic [ADDR_WIDTH-1:0] a_cur;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Backing-store port control.
    always_comb begin
        win_cur  = (timer_q >= WIN_LO) && (timer_q <= WIN_HI);
        beat_cur = BW'(timer_q - WIN_LO);
        a_cur    = addr_q + ADDR_WIDTH'(beat_cur);
        mem_we   = win_cur && wr_q;
        mem_addr = wr_q ? a_cur[MEM_AW-1:0] : a_nxt[MEM_AW-1:0];
    end

    psram_model_mem #(.AW(MEM_AW), .DW(DATA_WIDTH)) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_addr  (mem_addr),
        .i_wdata (bus.i_wr_data),
        .o_rdata (mem_rdata)
    );

    assign bus.o_rd_data = valid_q ? mem_rdata : '0;
`else
    logic [PAT_MAX_W-1:0]  pat_full;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Pattern for the next beat; zero outside the read window.
    always_comb begin
        pat_full = pattern_word(PATTERN_SEED, 32'(a_nxt));
        data_d   = valid_d ? pat_full[DATA_WIDTH-1:0] : '0;
    end

    // Read data register, aligned with valid_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) data_q <= '0;
        else          data_q <= data_d;
    end

    assign bus.o_rd_data = data_q;
`endif

    assign bus.o_rd_data_valid  = valid_q;
    assign bus.o_busy           = (timer_q != '0);
    assign bus.o_done           = (timer_q == T_END);
    assign bus.o_cmd_err        = err_q;
    assign bus.o_cmd_err_sticky = sticky_q;
endmodule
